// File: rtl/controller_fsm_nested.sv
// MiniRISC control FSM: fetch/decode/execute sequencing, nested prioritised
// interrupts with a priority stack, data-bus timeout abort and debug single-step.
module controller_fsm_nested #(
  parameter int unsigned NUM_IRQ     = 4,
  parameter int unsigned NEST_DEPTH  = 4,
  parameter int unsigned BUS_TIMEOUT = 15
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     i_addr_op2_sel,
  input  logic [3:0]                               i_opcode,
  input  logic [3:0]                               i_ctrl_op,
  input  logic                                     i_alu_flag_z,
  input  logic                                     i_alu_flag_c,
  input  logic                                     i_alu_flag_n,
  input  logic                                     i_alu_flag_v,
  input  logic [NUM_IRQ-1:0]                       i_irq,
  input  logic                                     i_flag_ie_din,
  input  logic                                     i_bus_grant,
  input  logic                                     i_dbg_break,
  input  logic                                     i_dbg_continue,
  input  logic                                     i_dbg_step,
  input  logic                                     i_dbg_ie_wr,
  input  logic                                     i_dbg_ie_din,
  input  logic                                     i_dbg_reg_wr,
  input  logic                                     i_dbg_mem_wr,
  input  logic                                     i_dbg_mem_rd,
  output logic                                     o_initialize,
  output logic                                     o_fetch,
  output logic                                     o_decode,
  output logic                                     o_interrupt,
  output logic [((NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1)-1:0] o_int_vector,
  output logic                                     o_ex_jump,
  output logic                                     o_ex_call,
  output logic                                     o_ex_ret_sub,
  output logic                                     o_ex_ret_int,
  output logic                                     o_wr_data_sel,
  output logic                                     o_reg_wr_en,
  output logic [1:0]                               o_alu_op_type,
  output logic                                     o_bus_req,
  output logic                                     o_data_mem_wr,
  output logic                                     o_data_mem_rd,
  output logic                                     o_bus_error,
  output logic                                     o_flag_ie,
  output logic                                     o_flag_if,
  output logic                                     o_dbg_is_brk
);

  localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned PW = $clog2(NUM_IRQ + 1);
  localparam int unsigned DW = $clog2(NEST_DEPTH + 1);
  localparam int unsigned SD = 1 << DW;
  localparam int unsigned CW = 8;

  localparam logic [3:0] OPCODE_ADD   = 4'h0;
  localparam logic [3:0] OPCODE_ADC   = 4'h1;
  localparam logic [3:0] OPCODE_SUB   = 4'h2;
  localparam logic [3:0] OPCODE_SBC   = 4'h3;
  localparam logic [3:0] OPCODE_AND   = 4'h4;
  localparam logic [3:0] OPCODE_OR    = 4'h5;
  localparam logic [3:0] OPCODE_XOR   = 4'h6;
  localparam logic [3:0] OPCODE_SHIFT = 4'h7;
  localparam logic [3:0] OPCODE_CMP   = 4'h8;
  localparam logic [3:0] OPCODE_TST   = 4'h9;
  localparam logic [3:0] OPCODE_MOV   = 4'hA;
  localparam logic [3:0] OPCODE_LD    = 4'hB;
  localparam logic [3:0] OPCODE_ST    = 4'hC;
  localparam logic [3:0] OPCODE_CTRL  = 4'hD;

  localparam logic [3:0] CTRL_JMP = 4'h0;
  localparam logic [3:0] CTRL_JZ  = 4'h1;
  localparam logic [3:0] CTRL_JNZ = 4'h2;
  localparam logic [3:0] CTRL_JC  = 4'h3;
  localparam logic [3:0] CTRL_JNC = 4'h4;
  localparam logic [3:0] CTRL_JN  = 4'h5;
  localparam logic [3:0] CTRL_JNN = 4'h6;
  localparam logic [3:0] CTRL_JV  = 4'h7;
  localparam logic [3:0] CTRL_JNV = 4'h8;
  localparam logic [3:0] CTRL_JSR = 4'h9;
  localparam logic [3:0] CTRL_RTS = 4'hA;
  localparam logic [3:0] CTRL_RTI = 4'hB;
  localparam logic [3:0] CTRL_STI = 4'hC;
  localparam logic [3:0] CTRL_CLI = 4'hD;

  localparam logic [1:0] ALU_MOVE  = 2'd0;
  localparam logic [1:0] ALU_ARITH = 2'd1;
  localparam logic [1:0] ALU_LOGIC = 2'd2;
  localparam logic [1:0] ALU_SHIFT = 2'd3;

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EX_LD    = 4'd3,
    ST_EX_ST    = 4'd4,
    ST_EX_MOV   = 4'd5,
    ST_EX_ARITH = 4'd6,
    ST_EX_LOGIC = 4'd7,
    ST_EX_SHIFT = 4'd8,
    ST_EX_CTRL  = 4'd9,
    ST_EX_NOP   = 4'd10,
    ST_INT_REQ  = 4'd11,
    ST_BREAK    = 4'd12
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_flag_ie;
  logic            r_flag_if;
  logic            r_bus_error;
  logic            r_step;
  logic [DW-1:0]   r_depth;
  logic [PW-1:0]   r_stack [SD];
  logic [PW-1:0]   r_int_sel;
  logic [CW-1:0]   r_to_cnt;

  logic [PW-1:0]   w_sel;
  logic [PW-1:0]   w_cur;
  logic [DW-1:0]   w_top_idx;
  logic [DW-1:0]   w_depth_nxt;
  logic            w_take_int;
  logic            w_timeout;
  logic            w_abort;
  logic            w_ex_done;
  logic            w_sti;
  logic            w_cli;
  logic            w_ie_nxt;

  // Priority select (index 0 wins) and the priority of the innermost active level
  always_comb begin
    w_sel = PW'(NUM_IRQ);
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (i_irq[i]) w_sel = PW'(i);
    end
    w_top_idx  = r_depth - DW'(1);
    w_cur      = (r_depth == '0) ? PW'(NUM_IRQ) : r_stack[w_top_idx];
    w_take_int = r_flag_ie & (|i_irq) & (w_sel < w_cur) & (r_depth < DW'(NEST_DEPTH));
    w_timeout  = (r_to_cnt == CW'(BUS_TIMEOUT - 1)) & ~i_bus_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_INIT;
    else        r_state <= w_next;
  end

  // Next state and decoded strobes
  always_comb begin
    w_next        = r_state;
    w_ex_done     = 1'b0;
    w_abort       = 1'b0;
    w_sti         = 1'b0;
    w_cli         = 1'b0;
    o_initialize  = 1'b0;
    o_fetch       = 1'b0;
    o_decode      = 1'b0;
    o_interrupt   = 1'b0;
    o_int_vector  = '0;
    o_ex_jump     = 1'b0;
    o_ex_call     = 1'b0;
    o_ex_ret_sub  = 1'b0;
    o_ex_ret_int  = 1'b0;
    o_wr_data_sel = 1'b0;
    o_reg_wr_en   = 1'b0;
    o_alu_op_type = ALU_MOVE;
    o_data_mem_wr = 1'b0;
    o_data_mem_rd = 1'b0;
    o_dbg_is_brk  = 1'b0;
    case (r_state)
      ST_INIT: begin
        o_initialize = 1'b1;
        w_next       = ST_FETCH;
      end
      ST_FETCH: begin
        o_fetch = ~(i_dbg_break | r_step);
        w_next  = (i_dbg_break | r_step) ? ST_BREAK : ST_DECODE;
      end
      ST_DECODE: begin
        o_decode = 1'b1;
        case (i_opcode)
          OPCODE_LD:    w_next = ST_EX_LD;
          OPCODE_ST:    w_next = ST_EX_ST;
          OPCODE_MOV:   w_next = ST_EX_MOV;
          OPCODE_ADD, OPCODE_ADC, OPCODE_SUB, OPCODE_SBC, OPCODE_CMP:
                        w_next = ST_EX_ARITH;
          OPCODE_AND, OPCODE_OR, OPCODE_XOR, OPCODE_TST:
                        w_next = ST_EX_LOGIC;
          OPCODE_SHIFT: w_next = i_addr_op2_sel ? ST_EX_SHIFT : ST_EX_LOGIC;
          OPCODE_CTRL:  w_next = ST_EX_CTRL;
          default:      w_next = ST_EX_NOP;
        endcase
      end
      ST_EX_LD: begin
        o_data_mem_rd = 1'b1;
        o_wr_data_sel = 1'b1;
        o_reg_wr_en   = i_bus_grant;
        w_abort       = w_timeout;
        w_ex_done     = i_bus_grant | w_timeout;
      end
      ST_EX_ST: begin
        o_data_mem_wr = 1'b1;
        w_abort       = w_timeout;
        w_ex_done     = i_bus_grant | w_timeout;
      end
      ST_EX_MOV: begin
        o_reg_wr_en = 1'b1;
        w_ex_done   = 1'b1;
      end
      ST_EX_ARITH: begin
        o_alu_op_type = ALU_ARITH;
        o_reg_wr_en   = ~i_opcode[3];
        w_ex_done     = 1'b1;
      end
      ST_EX_LOGIC: begin
        o_alu_op_type = ALU_LOGIC;
        o_reg_wr_en   = ~i_opcode[3];
        w_ex_done     = 1'b1;
      end
      ST_EX_SHIFT: begin
        o_alu_op_type = ALU_SHIFT;
        o_reg_wr_en   = 1'b1;
        w_ex_done     = 1'b1;
      end
      ST_EX_CTRL: begin
        w_ex_done = 1'b1;
        case (i_ctrl_op)
          CTRL_JMP: o_ex_jump    = 1'b1;
          CTRL_JZ:  o_ex_jump    = i_alu_flag_z;
          CTRL_JNZ: o_ex_jump    = ~i_alu_flag_z;
          CTRL_JC:  o_ex_jump    = i_alu_flag_c;
          CTRL_JNC: o_ex_jump    = ~i_alu_flag_c;
          CTRL_JN:  o_ex_jump    = i_alu_flag_n;
          CTRL_JNN: o_ex_jump    = ~i_alu_flag_n;
          CTRL_JV:  o_ex_jump    = i_alu_flag_v;
          CTRL_JNV: o_ex_jump    = ~i_alu_flag_v;
          CTRL_JSR: o_ex_call    = 1'b1;
          CTRL_RTS: o_ex_ret_sub = 1'b1;
          CTRL_RTI: o_ex_ret_int = 1'b1;
          CTRL_STI: w_sti        = 1'b1;
          CTRL_CLI: w_cli        = 1'b1;
          default:  ;
        endcase
      end
      ST_EX_NOP: w_ex_done = 1'b1;
      ST_INT_REQ: begin
        o_interrupt  = 1'b1;
        o_int_vector = IW'(r_int_sel);
        w_next       = ST_FETCH;
      end
      ST_BREAK: begin
        o_dbg_is_brk  = 1'b1;
        o_data_mem_rd = i_dbg_mem_rd;
        o_data_mem_wr = i_dbg_mem_wr;
        o_reg_wr_en   = i_dbg_reg_wr;
        if (i_dbg_continue | i_dbg_step) w_next = ST_DECODE;
      end
      default: w_next = ST_INIT;
    endcase
    if (w_ex_done) w_next = w_take_int ? ST_INT_REQ : ST_FETCH;
    o_bus_req = o_data_mem_rd | o_data_mem_wr;
  end

  // Interrupt-enable update and nesting depth bookkeeping
  always_comb begin
    w_ie_nxt = r_flag_ie;
    if (o_initialize | o_interrupt | w_cli)        w_ie_nxt = 1'b0;
    else if (w_sti)                                w_ie_nxt = 1'b1;
    else if (o_ex_ret_int)                         w_ie_nxt = i_flag_ie_din;
    else if (o_dbg_is_brk & i_dbg_ie_wr)           w_ie_nxt = i_dbg_ie_din;
    w_depth_nxt = r_depth;
    if (o_interrupt)                               w_depth_nxt = r_depth + DW'(1);
    else if (o_ex_ret_int && (r_depth != '0))      w_depth_nxt = r_depth - DW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_ie   <= 1'b0;
      r_flag_if   <= 1'b0;
      r_bus_error <= 1'b0;
      r_step      <= 1'b0;
      r_depth     <= '0;
      r_int_sel   <= '0;
      r_to_cnt    <= '0;
      for (int i = 0; i < int'(SD); i++) r_stack[i] <= '0;
    end else begin
      r_flag_ie   <= w_ie_nxt;
      r_flag_if   <= (w_depth_nxt != '0);
      r_bus_error <= w_abort;
      r_depth     <= w_depth_nxt;
      if (o_interrupt) r_stack[r_depth] <= r_int_sel;
      if (w_ex_done && w_take_int) r_int_sel <= w_sel;
      if ((r_state == ST_DECODE) && ((w_next == ST_EX_LD) || (w_next == ST_EX_ST)))
        r_to_cnt <= '0;
      else if (((r_state == ST_EX_LD) || (r_state == ST_EX_ST)) && !i_bus_grant)
        r_to_cnt <= r_to_cnt + CW'(1);
      // Step flag survives an interrupt entry so the break lands on the next fetch
      if ((r_state == ST_FETCH) && (w_next == ST_BREAK)) r_step <= 1'b0;
      else if ((r_state == ST_BREAK) && i_dbg_step)      r_step <= 1'b1;
    end
  end

  assign o_flag_ie   = r_flag_ie;
  assign o_flag_if   = r_flag_if;
  assign o_bus_error = r_bus_error;

endmodule

// File: tb/tb_controller_fsm_nested.sv
// Self-checking bench for controller_fsm_nested: expectations are queued as
// stimulus is applied and compared against the DUT outputs once they settle.
module tb_controller_fsm_nested;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SHIFT = 4'h7, OP_CMP = 4'h8, OP_MOV = 4'hA;
  localparam logic [3:0] OP_LD = 4'hB, OP_CTRL = 4'hD;
  localparam logic [3:0] C_JNZ = 4'h2, C_RTI = 4'hB, C_STI = 4'hC;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op2_sel, z, c, n, v, ie_din, grant;
  logic [3:0] opcode, ctrl_op;
  logic [3:0] irq;
  logic       dbg_break, dbg_continue, dbg_step, dbg_ie_wr, dbg_ie_din;
  logic       dbg_reg_wr, dbg_mem_wr, dbg_mem_rd;
  logic       initialize, fetch, decode, interrupt;
  logic [1:0] int_vector;
  logic       ex_jump, ex_call, ex_ret_sub, ex_ret_int;
  logic       wr_data_sel, reg_wr_en;
  logic [1:0] alu_op_type;
  logic       bus_req, data_mem_wr, data_mem_rd, bus_error;
  logic       flag_ie, flag_if, dbg_is_brk;

  always #5 clk = ~clk;

  controller_fsm_nested #(.NUM_IRQ(4), .NEST_DEPTH(2), .BUS_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr_op2_sel(op2_sel), .i_opcode(opcode), .i_ctrl_op(ctrl_op),
    .i_alu_flag_z(z), .i_alu_flag_c(c), .i_alu_flag_n(n), .i_alu_flag_v(v),
    .i_irq(irq), .i_flag_ie_din(ie_din), .i_bus_grant(grant),
    .i_dbg_break(dbg_break), .i_dbg_continue(dbg_continue), .i_dbg_step(dbg_step),
    .i_dbg_ie_wr(dbg_ie_wr), .i_dbg_ie_din(dbg_ie_din), .i_dbg_reg_wr(dbg_reg_wr),
    .i_dbg_mem_wr(dbg_mem_wr), .i_dbg_mem_rd(dbg_mem_rd),
    .o_initialize(initialize), .o_fetch(fetch), .o_decode(decode), .o_interrupt(interrupt),
    .o_int_vector(int_vector), .o_ex_jump(ex_jump), .o_ex_call(ex_call),
    .o_ex_ret_sub(ex_ret_sub), .o_ex_ret_int(ex_ret_int), .o_wr_data_sel(wr_data_sel),
    .o_reg_wr_en(reg_wr_en), .o_alu_op_type(alu_op_type), .o_bus_req(bus_req),
    .o_data_mem_wr(data_mem_wr), .o_data_mem_rd(data_mem_rd), .o_bus_error(bus_error),
    .o_flag_ie(flag_ie), .o_flag_if(flag_if), .o_dbg_is_brk(dbg_is_brk)
  );

  typedef enum {SG_INIT, SG_FETCH, SG_DECODE, SG_INT, SG_VEC, SG_JUMP, SG_REGWR, SG_ALU,
                SG_BUSREQ, SG_MEMRD, SG_BUSERR, SG_IE, SG_IF, SG_BRK, SG_WRSEL} sig_e;
  typedef struct { sig_e sig; logic [7:0] val; string tag; } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [7:0] observe(input sig_e s);
    case (s)
      SG_INIT:   return 8'(initialize);
      SG_FETCH:  return 8'(fetch);
      SG_DECODE: return 8'(decode);
      SG_INT:    return 8'(interrupt);
      SG_VEC:    return 8'(int_vector);
      SG_JUMP:   return 8'(ex_jump);
      SG_REGWR:  return 8'(reg_wr_en);
      SG_ALU:    return 8'(alu_op_type);
      SG_BUSREQ: return 8'(bus_req);
      SG_MEMRD:  return 8'(data_mem_rd);
      SG_BUSERR: return 8'(bus_error);
      SG_IE:     return 8'(flag_ie);
      SG_IF:     return 8'(flag_if);
      SG_BRK:    return 8'(dbg_is_brk);
      default:   return 8'(wr_data_sel);
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    if (obs !== expv) $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    else n_pass++;
  endtask

  task automatic push_exp(input sig_e s, input logic [7:0] v, input string tag);
    exp_t e;
    e.sig = s; e.val = v; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Let combinational outputs settle, then score everything queued
  task automatic drain();
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic go();
    @(negedge clk);
  endtask

  // From a FETCH cycle: run through DECODE and stop in the execute cycle
  task automatic to_ex(input logic [3:0] op, input logic [3:0] cop);
    opcode = op; ctrl_op = cop;
    push_exp(SG_FETCH, 1, "fetch"); drain(); go();
    push_exp(SG_DECODE, 1, "decode"); drain(); go();
  endtask

  initial begin
    int  cnt;
    logic saw_wr;
    rst_n = 1'b0; op2_sel = 0; z = 0; c = 0; n = 0; v = 0; ie_din = 0; grant = 0;
    opcode = OP_ADD; ctrl_op = 4'h0; irq = 4'b0000;
    dbg_break = 0; dbg_continue = 0; dbg_step = 0; dbg_ie_wr = 0; dbg_ie_din = 0;
    dbg_reg_wr = 0; dbg_mem_wr = 0; dbg_mem_rd = 0;

    go();
    push_exp(SG_INIT, 1, "rst_init"); push_exp(SG_IE, 0, "rst_ie"); push_exp(SG_IF, 0, "rst_if");
    push_exp(SG_BUSERR, 0, "rst_buserr"); push_exp(SG_BUSREQ, 0, "rst_busreq"); drain();
    rst_n = 1'b1;
    push_exp(SG_INIT, 1, "init_after_rel"); drain(); go();

    to_ex(OP_CMP, 0);
    push_exp(SG_ALU, 1, "cmp_alu"); push_exp(SG_REGWR, 0, "cmp_wr"); drain(); go();
    to_ex(OP_ADD, 0);
    push_exp(SG_ALU, 1, "add_alu"); push_exp(SG_REGWR, 1, "add_wr"); drain(); go();
    op2_sel = 1; to_ex(OP_SHIFT, 0);
    push_exp(SG_ALU, 3, "shift_alu"); push_exp(SG_REGWR, 1, "shift_wr"); drain(); go();
    op2_sel = 0; to_ex(OP_SHIFT, 0);
    push_exp(SG_ALU, 2, "swap_alu"); push_exp(SG_REGWR, 1, "swap_wr"); drain(); go();

    to_ex(OP_CTRL, C_JNZ);
    z = 0; push_exp(SG_JUMP, 1, "jnz_z0"); drain();
    z = 1; push_exp(SG_JUMP, 0, "jnz_z1"); drain(); go();
    z = 0;

    // Bus timeout: no grant at all
    to_ex(OP_LD, 0);
    cnt = 0; saw_wr = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!data_mem_rd) break;
      cnt++;
      if (reg_wr_en) saw_wr = 1;
      go();
    end
    check_eq("ld_timeout_cycles", 8'(cnt), 15);
    check_eq("ld_timeout_regwr", 8'(saw_wr), 0);
    push_exp(SG_FETCH, 1, "timeout_fetch"); push_exp(SG_BUSERR, 1, "buserr_pulse"); drain(); go();
    push_exp(SG_DECODE, 1, "ld2_decode"); push_exp(SG_BUSERR, 0, "buserr_one_cycle"); drain(); go();
    // Grant arrives on the last allowed cycle
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      #1;
      if (data_mem_rd) cnt++;
      go();
    end
    check_eq("ld_wait_cycles", 8'(cnt), 14);
    grant = 1;
    push_exp(SG_REGWR, 1, "ld_grant_wr"); push_exp(SG_WRSEL, 1, "ld_wrsel"); drain(); go();
    grant = 0;
    push_exp(SG_FETCH, 1, "ld_grant_fetch"); push_exp(SG_BUSERR, 0, "ld_grant_noerr"); drain();

    // Interrupt entry and nesting
    to_ex(OP_CTRL, C_STI); go();
    push_exp(SG_IE, 1, "sti_ie"); drain();
    irq = 4'b0100;
    to_ex(OP_MOV, 0);
    push_exp(SG_REGWR, 1, "mov_wr"); drain(); go();
    push_exp(SG_INT, 1, "irq2_int"); push_exp(SG_VEC, 2, "irq2_vec"); drain(); go();
    push_exp(SG_IF, 1, "irq2_if"); push_exp(SG_IE, 0, "irq2_ie"); drain();
    irq = 4'b1000;
    to_ex(OP_CTRL, C_STI); go();
    to_ex(OP_MOV, 0); go();
    push_exp(SG_INT, 0, "irq3_held"); push_exp(SG_FETCH, 1, "irq3_fetch"); drain();
    irq = 4'b0001;
    to_ex(OP_MOV, 0); go();
    push_exp(SG_INT, 1, "irq0_nest_int"); push_exp(SG_VEC, 0, "irq0_nest_vec"); drain(); go();
    irq = 4'b0000; ie_din = 1;
    to_ex(OP_CTRL, C_RTI); go();
    push_exp(SG_IE, 1, "rti_ie"); push_exp(SG_IF, 1, "rti_if_still"); drain();
    irq = 4'b0010;
    to_ex(OP_MOV, 0); go();
    push_exp(SG_INT, 1, "irq1_int"); push_exp(SG_VEC, 1, "irq1_vec"); drain(); go();
    to_ex(OP_CTRL, C_STI); go();
    irq = 4'b0001;
    to_ex(OP_MOV, 0); go();
    push_exp(SG_INT, 0, "depth_full_block"); drain();
    to_ex(OP_CTRL, C_RTI); go();
    push_exp(SG_INT, 0, "rti_at_full_noint"); drain();
    to_ex(OP_MOV, 0); go();
    push_exp(SG_INT, 1, "after_pop_int"); push_exp(SG_VEC, 0, "after_pop_vec"); drain(); go();
    irq = 4'b0000; ie_din = 0;
    to_ex(OP_CTRL, C_RTI); go();
    to_ex(OP_CTRL, C_RTI); go();
    push_exp(SG_IF, 0, "unwound_if"); push_exp(SG_IE, 0, "unwound_ie"); drain();
    ie_din = 1;
    to_ex(OP_CTRL, C_RTI); go();
    push_exp(SG_IE, 1, "rti_d0_ie"); push_exp(SG_IF, 0, "rti_d0_if"); drain();

    // Debug break, memory access, IE write and single step
    dbg_break = 1;
    push_exp(SG_FETCH, 0, "brk_fetch_low"); drain(); go();
    dbg_break = 0;
    push_exp(SG_BRK, 1, "in_break"); drain();
    dbg_mem_rd = 1;
    push_exp(SG_BUSREQ, 1, "dbg_busreq"); push_exp(SG_MEMRD, 1, "dbg_memrd"); drain();
    dbg_mem_rd = 0; dbg_ie_wr = 1; dbg_ie_din = 0; go();
    dbg_ie_wr = 0;
    push_exp(SG_IE, 0, "dbg_ie_clr"); push_exp(SG_BRK, 1, "break_holds"); drain();
    dbg_ie_wr = 1; dbg_ie_din = 1; go();
    dbg_ie_wr = 0;
    push_exp(SG_IE, 1, "dbg_ie_set"); drain();
    opcode = OP_MOV; dbg_step = 1; go();
    dbg_step = 0;
    push_exp(SG_DECODE, 1, "step_decode"); drain(); go();
    push_exp(SG_REGWR, 1, "step_ex"); drain(); go();
    push_exp(SG_FETCH, 0, "step_fetch_low"); drain(); go();
    push_exp(SG_BRK, 1, "step_rebreak"); drain();
    irq = 4'b0001; dbg_step = 1; go();
    dbg_step = 0; go(); go();
    push_exp(SG_INT, 1, "step_int"); push_exp(SG_VEC, 0, "step_int_vec"); drain(); go();
    irq = 4'b0000;
    push_exp(SG_FETCH, 0, "step_int_fetch_low"); drain(); go();
    push_exp(SG_BRK, 1, "step_int_break"); drain();

    // Asynchronous reset in the middle of a load
    opcode = OP_LD; dbg_continue = 1; go();
    dbg_continue = 0; go();
    push_exp(SG_MEMRD, 1, "pre_rst_ld"); push_exp(SG_IF, 1, "pre_rst_if"); drain();
    rst_n = 1'b0;
    push_exp(SG_INIT, 1, "mid_rst_init"); push_exp(SG_IE, 0, "mid_rst_ie");
    push_exp(SG_IF, 0, "mid_rst_if"); push_exp(SG_BUSREQ, 0, "mid_rst_busreq"); drain(); go();
    rst_n = 1'b1;
    push_exp(SG_INIT, 1, "rel_init"); drain(); go();
    push_exp(SG_FETCH, 1, "rel_fetch"); push_exp(SG_INIT, 0, "rel_init_done"); drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/controller_fsm_nested.md
Name: controller_fsm_nested

Overview:
- Next-generation MiniRISC control state machine: sequences init, fetch, decode and execute, bus access, interrupt entry and debug break.
- Adds a parametrised multi-line prioritised interrupt input with nested-interrupt priority stack, data-bus timeout abort, and debug single-step.
- Sits between the instruction register/decoder, datapath (ALU, register file, PC/stack logic) and data bus arbiter.

Parameters:
NUM_IRQ, 4, interrupt request lines; index 0 = highest priority (2..16)
NEST_DEPTH, 4, maximum nesting depth of active interrupts (1..8)
BUS_TIMEOUT, 15, cycles waiting for bus_grant before abort (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
addr_op2_sel  in  1  operand-2 select bit of instruction (shift vs swap)
opcode  in  4  instruction opcode (shared OPCODE_* constants)
ctrl_op  in  4  control-op code (shared CTRL_* constants)
alu_flag_z/c/n/v  in  1 each  ALU flags
irq  in  NUM_IRQ  level-sensitive interrupt requests
flag_ie_din  in  1  IE value restored on RTI
bus_grant  in  1  data bus grant
dbg_break, dbg_continue, dbg_step  in  1 each  debug halt / resume / single-step
dbg_ie_wr, dbg_ie_din, dbg_reg_wr, dbg_mem_wr, dbg_mem_rd  in  1 each  debug accesses, valid in BREAK only
initialize, fetch, decode, interrupt  out  1 each  state strobes
int_vector  out  clog2(NUM_IRQ)  index of interrupt being entered, valid while interrupt=1
ex_jump, ex_call, ex_ret_sub, ex_ret_int  out  1 each  control-op execute strobes
wr_data_sel, reg_wr_en  out  1 each  register write source (1 = bus read data) / enable
alu_op_type  out  2  ALU_MOVE/ARITH/LOGIC/SHIFT
bus_req, data_mem_wr, data_mem_rd  out  1 each  data bus control
bus_error  out  1  one-cycle pulse on bus timeout abort
flag_ie, flag_if  out  1 each  interrupt enable / in-service (nest depth != 0)
dbg_is_brk  out  1  in BREAK state

Behaviour:
- Reset (rst_n=0, async): state INIT; stack depth 0; timeout counter 0; step flag 0. flag_ie=0, flag_if=0, bus_error=0.
- All outputs are combinational decodes of state and inputs, except flag_ie, flag_if and bus_error, which are registered.

States: INIT, FETCH, DECODE, EX_LD, EX_ST, EX_MOV, EX_ARITH, EX_LOGIC, EX_SHIFT, EX_CTRL, EX_NOP, INT_REQ, BREAK.
- INIT -> FETCH.
- FETCH -> BREAK if dbg_break or step flag set, else DECODE. fetch = ~(dbg_break|step).
- DECODE:
  - LD -> EX_LD; ST -> EX_ST; MOV -> EX_MOV.
  - ADD/ADC/SUB/SBC/CMP -> EX_ARITH.
  - AND/OR/XOR/TST -> EX_LOGIC.
  - SHIFT opcode: addr_op2_sel ? EX_SHIFT : EX_LOGIC.
  - CTRL -> EX_CTRL; any other opcode -> EX_NOP.
- Every EX_* state, on completion: INT_REQ if take_int, else FETCH.
  - EX_LD/EX_ST complete on bus_grant or on timeout.
- INT_REQ -> FETCH. BREAK -> DECODE on dbg_continue or dbg_step; otherwise stay.
- Invalid state codes -> INIT.

Interrupt arbitration:
- sel = lowest index i with irq[i]=1.
- cur = priority on top of stack; NUM_IRQ when depth = 0.
- take_int = flag_ie & |irq & (sel < cur) & (depth < NEST_DEPTH).
- Equal or lower priority requests are held off until a return.
- In INT_REQ: push sel, depth+1, flag_ie <= 0, int_vector = sel.
- RTI (ex_ret_int) with depth > 0: pop, depth-1, flag_ie <= flag_ie_din. RTI at depth 0: no pop, flag_ie <= flag_ie_din.
- flag_ie priority, highest first:
  1. clear on initialize / interrupt / CLI
  2. set on STI
  3. RTI load
  4. debug write in BREAK

Bus and timeout:
- EX_LD: data_mem_rd=1, wr_data_sel=1, reg_wr_en=bus_grant.
- EX_ST: data_mem_wr=1.
- BREAK: data_mem_rd/wr follow dbg_mem_rd/wr; reg_wr_en=dbg_reg_wr.
- bus_req = data_mem_rd | data_mem_wr.
- Counter clears on entering EX_LD/EX_ST and increments each cycle without grant.
- When counter = BUS_TIMEOUT-1 and bus_grant=0: abort, reg_wr_en=0, bus_error=1 next cycle, leave state as completed.
- Grant on the timeout cycle counts as success, not abort.

Register writes:
- reg_wr_en: EX_MOV=1, EX_SHIFT=1, EX_ARITH/EX_LOGIC = ~opcode[3], else 0.

ex_jump: in EX_CTRL only, by ctrl_op.
- JMP=1; JZ/JNZ = z/~z; JC/JNC = c/~c; JN/JNN = n/~n; JV/JNV = v/~v; other ctrl_op = 0.
- ex_call = JSR; ex_ret_sub = RTS; ex_ret_int = RTI.

Single step:
- dbg_step in BREAK sets step flag and leaves to DECODE.
- Step flag clears on the next entry to BREAK.
- An interrupt taken during a step executes INT_REQ, then breaks at the following FETCH.

Test Plan:
- Reset mid-EX_LD (rst_n low 1 cycle) -> next cycle state INIT, flag_ie=0, flag_if=0, bus_req=0; after release, initialize=1 for 1 cycle, then fetch=1.
- NUM_IRQ=4, flag_ie=1, irq=4'b0100 during EX_MOV -> INT_REQ with int_vector=2, flag_if=1, flag_ie=0.
  - Then STI, raise irq[0] -> nested INT_REQ, int_vector=0.
  - Raise irq[3] instead -> no entry.
- NEST_DEPTH=2 with two nested levels active, irq[0] asserted, flag_ie=1 -> no INT_REQ.
  - RTI with flag_ie_din=1 -> depth 1; next EX completion enters INT_REQ, int_vector=0.
- BUS_TIMEOUT=15, LD with bus_grant held 0 -> exactly 15 cycles in EX_LD, reg_wr_en never 1, bus_error pulse 1 cycle, then FETCH.
  - Repeat with grant on the 15th cycle -> reg_wr_en=1, no bus_error.
- JNZ with z=0 -> ex_jump=1; z=1 -> ex_jump=0. CMP in EX_ARITH -> reg_wr_en=0, alu_op_type=ALU_ARITH.
- dbg_break at FETCH -> BREAK; dbg_step -> DECODE, EX_*, FETCH, back to BREAK with fetch=0 and dbg_break low.
  - In BREAK: dbg_mem_rd=1 -> bus_req=1, data_mem_rd=1.
